// File: rtl/bitwise_unit_pkg.sv
// Shared op codes and FSM state encoding for the sequential bitwise/compare unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bitwise_unit_pkg;

  typedef enum logic [1:0] {
    OP_ZERO = 2'b00,
    OP_XOR  = 2'b01,
    OP_AND  = 2'b10,
    OP_OR   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bitwise_slice.sv
// One SLICE-bit step: bitwise op plus carry-in of the running ne / lt compare state.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module bitwise_slice
  import bitwise_unit_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  op_t              op,
  input  logic [SLICE-1:0] a_k,
  input  logic [SLICE-1:0] b_k,
  input  logic             lt_in,
  input  logic             ne_in,
  output logic [SLICE-1:0] q_k,
  output logic             lt_out,
  output logic             ne_out
);

  // Bitwise result for this slice; OP_ZERO forces zero.
  always_comb begin
    q_k = '0;
    unique case (op)
      OP_XOR:  q_k = a_k ^ b_k;
      OP_AND:  q_k = a_k & b_k;
      OP_OR:   q_k = a_k | b_k;
      default: q_k = '0;
    endcase
  end

  // Slices arrive LSB first, so a strict difference in a higher slice overrides
  // whatever the lower slices decided; equality passes the lower verdict through.
  always_comb begin
    lt_out = (a_k < b_k) | ((a_k == b_k) & lt_in);
    ne_out = ne_in | (a_k != b_k);
  end

endmodule

// File: rtl/bitwise_unit_seq.sv
// Multi-cycle bitwise logic + compare unit, SLICE bits per cycle, LSB slice first.
// Latency: N = WIDTH/SLICE cycles from accept to out_valid; one op per N+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
// Optional feature macro: BITWISE_UNIT_SIGNED_EN adds the sgn port for signed lt.
module bitwise_unit_seq
  import bitwise_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BITWISE_UNIT_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             ne,
  output logic             lt
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt_q;
  logic             ne_acc_q;
  logic             lt_acc_q;
  logic             ne_q;
  logic             lt_q;
  logic             sgn_fix;

  logic [SLICE-1:0] a_k;
  logic [SLICE-1:0] b_k;
  logic [SLICE-1:0] q_k;
  logic             lt_out;
  logic             ne_out;

`ifdef BITWISE_UNIT_SIGNED_EN
  logic sgn_q;
  // Signed compare: differing MSBs invert the unsigned verdict.
  assign sgn_fix = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`else
  assign sgn_fix = 1'b0;
`endif

  // Select the operand slice addressed by the slice counter.
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_k = a_q[k*SLICE +: SLICE];
        b_k = b_q[k*SLICE +: SLICE];
      end
    end
  end

  bitwise_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op     (op_q),
    .a_k    (a_k),
    .b_k    (b_k),
    .lt_in  (lt_acc_q),
    .ne_in  (ne_acc_q),
    .q_k    (q_k),
    .lt_out (lt_out),
    .ne_out (ne_out)
  );

  // FSM, slice counter, operand capture, accumulators and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ZERO;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      ne_acc_q <= 1'b0;
      lt_acc_q <= 1'b0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
`ifdef BITWISE_UNIT_SIGNED_EN
      sgn_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= op_t'(op);
            a_q      <= a;
            b_q      <= b;
            cnt_q    <= '0;
            ne_acc_q <= 1'b0;
            lt_acc_q <= 1'b0;
`ifdef BITWISE_UNIT_SIGNED_EN
            sgn_q    <= sgn;
`endif
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
              q_q[k*SLICE +: SLICE] <= q_k;
            end
          end
          ne_acc_q <= ne_out;
          lt_acc_q <= lt_out;
          if (cnt_q == CNT_LAST) begin
            // Publish flags only on entry to DONE so they stay put while held.
            ne_q    <= ne_out;
            lt_q    <= lt_out ^ sgn_fix;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode state only; data outputs come straight from registers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    q         = q_q;
    ne        = ne_q;
    lt        = lt_q;
  end

endmodule

// File: tb/tb_bitwise_unit_seq.sv
// Directed bench for bitwise_unit_seq: vector table plus hold, reset-abort and N=1 sequences.
module tb_bitwise_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  // Main instance: WIDTH=16, SLICE=4
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] a, b, q;
  logic        ne, lt;

  // Single-slice instance: WIDTH=SLICE=8
  logic        v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready;
  logic [1:0]  v8_op;
  logic [7:0]  v8_a, v8_b, v8_q;
  logic        v8_ne, v8_lt;

`ifdef BITWISE_UNIT_SIGNED_EN
  logic        sgn, v8_sgn;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitwise_unit_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
`ifdef BITWISE_UNIT_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ne        (ne),
    .lt        (lt)
  );

  bitwise_unit_seq #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8_in_valid),
    .in_ready  (v8_in_ready),
    .op        (v8_op),
    .a         (v8_a),
    .b         (v8_b),
`ifdef BITWISE_UNIT_SIGNED_EN
    .sgn       (v8_sgn),
`endif
    .out_valid (v8_out_valid),
    .out_ready (v8_out_ready),
    .q         (v8_q),
    .ne        (v8_ne),
    .lt        (v8_lt)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [15:0] q;
    logic        ne;
    logic        lt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Full transaction on the main instance with out_ready held high.
  task automatic run_op(input vec_t v, input string nm);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    op        = v.op;
    a         = v.a;
    b         = v.b;
`ifdef BITWISE_UNIT_SIGNED_EN
    sgn       = v.sgn;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Operands are free to change after acceptance.
    a  = ~v.a;
    b  = ~v.b;
    op = ~v.op;
`ifdef BITWISE_UNIT_SIGNED_EN
    sgn = ~v.sgn;
`endif
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd4);
    chk({nm, "_q"},  32'(q),  32'(v.q));
    chk({nm, "_ne"}, 32'(ne), 32'(v.ne));
    chk({nm, "_lt"}, 32'(lt), 32'(v.lt));
    @(negedge clk);
    chk({nm, "_idle_after_hs"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic bad;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    op           = 2'b00;
    a            = '0;
    b            = '0;
    v8_in_valid  = 1'b0;
    v8_out_ready = 1'b0;
    v8_op        = 2'b00;
    v8_a         = '0;
    v8_b         = '0;
`ifdef BITWISE_UNIT_SIGNED_EN
    sgn          = 1'b0;
    v8_sgn       = 1'b0;
`endif

    //           op     a         b         sgn   q         ne    lt
    tbl.push_back('{2'b01, 16'h00FF, 16'h0F0F, 1'b0, 16'h0FF0, 1'b1, 1'b1});
    tbl.push_back('{2'b10, 16'h1234, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0});
    tbl.push_back('{2'b11, 16'h8000, 16'h0001, 1'b0, 16'h8001, 1'b1, 1'b0});
    tbl.push_back('{2'b10, 16'hFFFF, 16'h0F0F, 1'b0, 16'h0F0F, 1'b1, 1'b0});
    tbl.push_back('{2'b00, 16'h1234, 16'h1235, 1'b0, 16'h0000, 1'b1, 1'b1});
    tbl.push_back('{2'b11, 16'h1230, 16'h1240, 1'b0, 16'h1270, 1'b1, 1'b1});
    tbl.push_back('{2'b01, 16'hF000, 16'h0FFF, 1'b0, 16'hFFFF, 1'b1, 1'b0});
`ifdef BITWISE_UNIT_SIGNED_EN
    tbl.push_back('{2'b11, 16'h8000, 16'h0001, 1'b1, 16'h8001, 1'b1, 1'b1});
    tbl.push_back('{2'b01, 16'h0001, 16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 1'b0});
    tbl.push_back('{2'b01, 16'h0001, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b1});
`endif

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q",         32'(q),         32'd0);
    chk("rst_flags",     32'({ne, lt}),  32'd0);
    chk("rst8_state",    32'({v8_in_ready, v8_out_valid}), 32'b10);

    // Table-driven vectors
    foreach (tbl[i]) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
    end

    // Result held under backpressure; requests during DONE are ignored
    op        = 2'b00;
    a         = 16'hFFFF;
    b         = 16'h0000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_latency", 32'(lat), 32'd4);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (!(out_valid === 1'b1 && q === 16'h0000 && ne === 1'b1 && lt === 1'b0 && in_ready === 1'b0))
        bad = 1'b1;
      op       = 2'b11;
      a        = 16'h1234;
      b        = 16'h5678;
      in_valid = 1'b1;
      @(negedge clk);
    end
    chk("hold_stable", 32'(bad), 32'd0);
    chk("hold_q", 32'({out_valid, in_ready, q, ne, lt}), 32'({1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", 32'({out_valid, in_ready}), 32'b01);
    chk("hold_no_accept_q", 32'(q), 32'h0000);
    @(negedge clk);
    chk("hold_still_idle", 32'({out_valid, in_ready}), 32'b01);

    // Reset during slice 2 abandons the operation
    op       = 2'b01;
    a        = 16'h00FF;
    b        = 16'h0F0F;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    chk("midrst_no_pulse", 32'(bad), 32'd0);
    run_op('{2'b01, 16'h0001, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b1}, "after_rst");

    // Single-slice configuration: N=1
    v8_op        = 2'b11;
    v8_a         = 8'h01;
    v8_b         = 8'h02;
    v8_in_valid  = 1'b1;
    v8_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8_in_valid = 1'b0;
    v8_a        = 8'hFF;
    v8_b        = 8'hFF;
    lat = 0;
    while (!v8_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("n1_latency", 32'(lat),   32'd1);
    chk("n1_q",       32'(v8_q),  32'h03);
    chk("n1_flags",   32'({v8_ne, v8_lt}), 32'b11);
    @(negedge clk);
    chk("n1_idle", 32'({v8_out_valid, v8_in_ready}), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_unit_seq.md
# bitwise_unit_seq

Multi-cycle, parametrised bitwise logic and compare unit; the multi-bit successor to the single-bit bitwise/compare slice in the ALU datapath. It accepts two WIDTH-bit operands and a 2-bit op over a valid/ready handshake. It processes them SLICE bits per cycle, LSB slice first, carrying the compare state between cycles in registers. It returns the bitwise result together with not-equal and less-than flags.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of SLICE.
- SLICE, 4, bits processed per cycle; N = WIDTH/SLICE slice cycles.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit idle and able to accept.
- op  input  2  00 zero, 01 xor, 10 and, 11 or.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- q  output  WIDTH  bitwise result.
- ne  output  1  a != b.
- lt  output  1  a < b, unsigned (signed variant under Configuration).

## Operation
- Only one clock and one reset: clk, with rst_n asynchronous and active-low.
- States: IDLE, BUSY, DONE. in_ready = (state == IDLE).
- IDLE: on in_valid && in_ready, register op, a and b, clear slice counter, ne_acc and lt_acc, then go to BUSY.
- BUSY: each cycle process slice k (bits k*SLICE+SLICE-1 .. k*SLICE).
  - Write the q slice for op.
  - ne_acc |= (a_k != b_k).
  - lt_acc = (a_k < b_k) | ((a_k == b_k) & lt_acc).
  - After slice N-1, go to DONE.
- DONE: out_valid = 1. q, ne and lt are stable until out_valid && out_ready, then go to IDLE.
- op=00 gives q = 0. ne and lt are always computed, independent of op.
- in_valid is ignored outside IDLE, and inputs are not sampled then. Operands may change freely after acceptance.
- No overlap: a new request cannot be accepted in the same cycle as the output handshake.
- Reset, including mid-BUSY or mid-DONE, abandons the operation with no out_valid pulse.
- Reset values:
  - state IDLE, so in_ready = 1.
  - out_valid = 0.
  - q = 0, ne = 0, lt = 0.
  - Counter and accumulators 0.

## Timing
- Accept on edge E0. Slice k is registered on edge E(k+1). out_valid rises after edge EN, i.e. latency is N cycles from acceptance.
- Output handshake on edge Ed puts the unit in IDLE after Ed, with in_ready high in the following cycle.
- Back-to-back throughput: one operation per N+2 cycles with out_ready held high.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Counter width is clog2(N), minimum 1. The counter reaches N-1 exactly once per operation and never wraps in BUSY.

## Configuration
- Macro: BITWISE_UNIT_SIGNED_EN.
- Defined:
  - Adds input port sgn (1 bit), sampled at acceptance.
  - When sgn = 1, lt = lt_acc ^ (a[WIDTH-1] ^ b[WIDTH-1]), i.e. two's-complement less-than. This correction is applied when entering DONE.
  - When sgn = 0, lt is unsigned.
- Undefined: no sgn port, and lt is always unsigned.

## Structure
- Package bitwise_unit_pkg holds:
  - op codes OP_ZERO, OP_XOR, OP_AND, OP_OR.
  - State encoding ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module bitwise_slice is a combinational SLICE-bit cell with inputs op, a_k, b_k, lt_in and ne_in, and outputs q_k, lt_out and ne_out. It has a single instance, driven by a counter-selected operand slice.
- The top level holds the FSM, counter, operand/result registers and handshake logic.

## Test plan
- WIDTH=16, SLICE=4, op=01, a=0x00FF, b=0x0F0F -> q=0x0FF0, ne=1, lt=1; out_valid exactly 4 cycles after accept.
- op=10, a=b=0x1234 -> q=0x1234, ne=0, lt=0.
- op=11, a=0x8000, b=0x0001 -> q=0x8001, ne=1, lt=0. With BITWISE_UNIT_SIGNED_EN and sgn=1 -> lt=1. With sgn=0 -> lt=0.
- op=00, a=0xFFFF, b=0x0000, out_ready low 5 cycles after out_valid -> q=0, ne=1, lt=0; outputs held, in_ready=0, and a concurrent in_valid is not accepted.
- rst_n pulsed low during slice 2 -> out_valid stays 0, and in_ready=1 after release. The next op (op=01, a=0x0001, b=0x0003) gives q=0x0002, ne=1, lt=1.
- WIDTH=SLICE=8 (N=1), op=11, a=0x01, b=0x02 -> q=0x03, ne=1, lt=1; out_valid 1 cycle after accept.
